// File: rtl/crc_pkg.sv
// crc_pkg: shared FSM state type and standard USB CRC constants for the serial CRC engine.
package crc_pkg;
  typedef enum logic [1:0] {IDLE, DATA, TAIL} crc_state_t;
  localparam logic [4:0]  USB_CRC5_POLY  = 5'b00101;
  localparam logic [4:0]  USB_CRC5_RES   = 5'b01100;
  localparam logic [15:0] USB_CRC16_POLY = 16'h8005;
  localparam logic [15:0] USB_CRC16_RES  = 16'h800D;
endpackage

// File: rtl/crc_stream_append_lfsr.sv
// crc_lfsr: serial CRC shift register with data step, zero-fill tail shift and init reload.
module crc_lfsr
  import crc_pkg::*;
#(
  parameter int              CRC_W = 5,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(USB_CRC5_POLY),
  parameter logic [CRC_W-1:0] INIT = '1
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic             step,
  input  logic             tail_shift,
  input  logic             init,
  input  logic             inb,
  output logic [CRC_W-1:0] crc
);
  logic fb;
  assign fb = crc[CRC_W-1] ^ inb;
  always_ff @(posedge clk or negedge rst_L)
    if (!rst_L) crc <= INIT;
    else if (init) crc <= INIT;
    else if (step) crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    else if (tail_shift) crc <= {crc[CRC_W-2:0], 1'b0};
endmodule

// File: rtl/crc_stream_append.sv
// crc_stream_append: serial CRC generator/appender and checker with pause propagation.
module crc_stream_append
  import crc_pkg::*;
#(
  parameter int               CRC_W    = 5,
  parameter logic [CRC_W-1:0] POLY     = CRC_W'(USB_CRC5_POLY),
  parameter logic [CRC_W-1:0] INIT     = '1,
  parameter logic             INV_OUT  = 1'b1,
  parameter logic [CRC_W-1:0] RESIDUAL = CRC_W'(USB_CRC5_RES)
) (
  input  logic clk,
  input  logic rst_L,
  input  logic check,
  input  logic inb,
  input  logic recving,
  input  logic pause_out,
  output logic pause_in,
  output logic outb,
  output logic sending,
  output logic crc_ok,
  output logic crc_err
);
  localparam int CNT_W = $clog2(CRC_W);
  crc_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             mode;
  logic [CRC_W-1:0] crc;
  logic             data_cyc, gen_tail, chk_end, last, tail_bit;
  assign data_cyc = recving & (state != TAIL);
  assign gen_tail = (state == DATA & !recving & !mode) | state == TAIL;
  assign chk_end  = state == DATA & !recving & mode;
  assign last     = state == TAIL & cnt == CNT_W'(CRC_W - 1);
  assign tail_bit = crc[CRC_W-1] ^ INV_OUT;
  // Gating with rst_L keeps every output low while reset is held, even if upstream keeps driving.
  assign outb     = rst_L & (data_cyc ? inb : gen_tail & tail_bit);
  assign sending  = rst_L & (data_cyc | gen_tail);
  assign pause_in = rst_L & (state == TAIL | pause_out);
  assign crc_ok   = rst_L & chk_end & (crc == RESIDUAL);
  assign crc_err  = rst_L & chk_end & (crc != RESIDUAL);
  crc_lfsr #(.CRC_W(CRC_W), .POLY(POLY), .INIT(INIT)) u_lfsr (
    .clk       (clk),
    .rst_L     (rst_L),
    .step      (data_cyc & !pause_out),
    .tail_shift(gen_tail & !pause_out & !last),
    .init      (chk_end | (last & !pause_out)),
    .inb       (inb),
    .crc       (crc)
  );
  // A paused first bit leaves the FSM in IDLE; the same bit is re-presented and taken later.
  always_ff @(posedge clk or negedge rst_L)
    if (!rst_L) begin
      state <= IDLE;
      cnt   <= '0;
      mode  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (recving & !pause_out) begin
          state <= DATA;
          mode  <= check;
        end
        DATA: if (!recving & (mode | !pause_out)) begin
          state <= mode ? IDLE : TAIL;
          cnt   <= mode ? '0 : CNT_W'(1);
        end
        TAIL: if (!pause_out) begin
          state <= last ? IDLE : TAIL;
          cnt   <= last ? '0 : cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_crc_stream_append.sv
// tb_crc_stream_append: randomized frames on CRC5 and CRC16 instances checked every cycle against a bit-list model.
module tb_crc_stream_append;
  logic clk = 1'b0, rst_L = 1'b0, check = 1'b0, inb = 1'b0, recving = 1'b0, pause_out = 1'b0;
  logic o5_pause_in, o5_outb, o5_sending, o5_ok, o5_err;
  logic o16_pause_in, o16_outb, o16_sending, o16_ok, o16_err;
  logic sel16 = 1'b0;
  logic a_pause_in, a_outb, a_sending, a_ok, a_err;
  logic e_valid = 1'b0, e_outb = 1'b0, e_sending = 1'b0, e_pause_in = 1'b0, e_ok = 1'b0, e_err = 1'b0;
  int checks = 0, failures = 0;
  logic [63:0] obs_val = '0;
  int obs_n = 0, n_send = 0, n_ok = 0, n_err = 0;
  int W = 5;
  logic [15:0] poly = 16'h0005, res = 16'h000C, mask = 16'h001F;

  always #5 clk = ~clk;

  crc_stream_append dut5 (
    .clk(clk), .rst_L(rst_L), .check(check), .inb(inb), .recving(recving), .pause_out(pause_out),
    .pause_in(o5_pause_in), .outb(o5_outb), .sending(o5_sending), .crc_ok(o5_ok), .crc_err(o5_err)
  );
  crc_stream_append #(.CRC_W(16), .POLY(16'h8005), .INIT(16'hFFFF), .INV_OUT(1'b1), .RESIDUAL(16'h800D)) dut16 (
    .clk(clk), .rst_L(rst_L), .check(check), .inb(inb), .recving(recving), .pause_out(pause_out),
    .pause_in(o16_pause_in), .outb(o16_outb), .sending(o16_sending), .crc_ok(o16_ok), .crc_err(o16_err)
  );

  assign a_pause_in = sel16 ? o16_pause_in : o5_pause_in;
  assign a_outb     = sel16 ? o16_outb     : o5_outb;
  assign a_sending  = sel16 ? o16_sending  : o5_sending;
  assign a_ok       = sel16 ? o16_ok       : o5_ok;
  assign a_err      = sel16 ? o16_err      : o5_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (e_valid) begin
      chk("outb", 64'(a_outb), 64'(e_outb));
      chk("sending", 64'(a_sending), 64'(e_sending));
      chk("pause_in", 64'(a_pause_in), 64'(e_pause_in));
      chk("crc_ok", 64'(a_ok), 64'(e_ok));
      chk("crc_err", 64'(a_err), 64'(e_err));
    end
    if (a_sending && !pause_out) begin
      obs_val = {obs_val[62:0], a_outb};
      obs_n++;
    end
    if (a_sending) n_send++;
    if (a_ok) n_ok++;
    if (a_err) n_err++;
  end

  function automatic logic [15:0] crc_of(input bit b[$]);
    logic [15:0] r = mask;
    foreach (b[k]) r = ((r << 1) ^ ((r[W-1] ^ b[k]) ? poly : 16'h0)) & mask;
    return r;
  endfunction

  function automatic void with_crc(input bit b[$], output bit o[$]);
    logic [15:0] c = crc_of(b);
    o = b;
    for (int k = W - 1; k >= 0; k--) o.push_back(~c[k]);
  endfunction

  task automatic clear_obs();
    obs_val = '0; obs_n = 0; n_send = 0; n_ok = 0; n_err = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rst_L = 1'b1; recving = 1'b0; inb = 1'($urandom); pause_out = 1'($urandom); check = 1'($urandom);
      e_outb = 1'b0; e_sending = 1'b0; e_pause_in = pause_out; e_ok = 1'b0; e_err = 1'b0;
      e_valid = 1'b1;
    end
  endtask

  task automatic reset_seq();
    @(posedge clk); #1;
    rst_L = 1'b0; recving = 1'b1; inb = 1'b1; pause_out = 1'b1;
    e_outb = 1'b0; e_sending = 1'b0; e_pause_in = 1'b0; e_ok = 1'b0; e_err = 1'b0;
    e_valid = 1'b1;
    idle(2);
  endtask

  // pmode: 0 no pause, 1 random pause, 2 pause held 3 cycles in the middle of the tail
  task automatic run_frame(input bit bits[$], input bit cmode, input int pmode, input int abort);
    bit tl[$];
    logic [15:0] c;
    int n, total, i, held, cyc;
    bit done, p;
    n = bits.size(); c = crc_of(bits); tl = bits;
    if (!cmode) for (int k = W - 1; k >= 0; k--) tl.push_back(~c[k]);
    total = tl.size(); i = 0; held = 0; cyc = 0; done = 0;
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      p = pmode == 1 ? ($urandom_range(3) == 0 && cyc < 200) : pmode == 2 ? (i == n + 2 && held < 3) : 1'b0;
      if (pmode == 2 && p) held++;
      rst_L = 1'b1; pause_out = p; check = cmode; e_ok = 1'b0; e_err = 1'b0;
      if (abort >= 0 && i == n + abort) begin
        rst_L = 1'b0; recving = 1'b1; inb = 1'b1; pause_out = 1'b1;
        e_outb = 1'b0; e_sending = 1'b0; e_pause_in = 1'b0;
        done = 1;
      end else if (i < n) begin
        recving = 1'b1; inb = tl[i]; e_outb = tl[i]; e_sending = 1'b1; e_pause_in = p;
      end else if (i < total) begin
        recving = 1'b0; inb = 1'($urandom); e_outb = tl[i]; e_sending = 1'b1; e_pause_in = (i == n) ? p : 1'b1;
      end else begin
        recving = 1'b0; inb = 1'($urandom); e_outb = 1'b0; e_sending = 1'b0; e_pause_in = p;
        e_ok = (c == res); e_err = (c != res);
        done = 1;
      end
      e_valid = 1'b1;
      if (!p) i++;
      if (!cmode && i == total) done = 1;
      if (cyc > 2000) begin
        chk("frame_timeout", 64'(cyc), 64'd2000);
        done = 1;
      end
    end
  endtask

  task automatic random_frames(input int cnt);
    bit b[$], f[$];
    bit cm;
    for (int t = 0; t < cnt; t++) begin
      b = {};
      repeat ($urandom_range(24, 1)) b.push_back(1'($urandom));
      cm = 1'($urandom);
      if (cm && $urandom_range(1)) with_crc(b, f); else f = b;
      run_frame(f, cm, 1, -1);
      if ($urandom_range(2) != 0) idle($urandom_range(2, 1));
    end
  endtask

  initial begin
    bit z[$], one[$], tok[$], full[$], bad[$], rnd[$];
    z = {1'b0};
    one = {1'b1};
    tok = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    reset_seq();

    chk("model_crc5_bit0", 64'(crc_of(z)), 64'h1B);
    clear_obs(); run_frame(z, 1'b0, 0, -1); idle(2);
    chk("s1_send_cycles", 64'(n_send), 64'd6);
    chk("s1_wire", obs_val, 64'b000100);

    chk("model_token_tail", 64'(crc_of(tok) ^ 16'h1F), 64'h17);
    clear_obs(); run_frame(tok, 1'b0, 0, -1); idle(1);
    chk("s3_tail", 64'(obs_val[4:0]), 64'h17);
    chk("s3_send_cycles", 64'(n_send), 64'd16);
    clear_obs(); run_frame(tok, 1'b0, 2, -1); idle(1);
    chk("s3p_tail", 64'(obs_val[4:0]), 64'h17);
    chk("s3p_send_cycles", 64'(n_send), 64'd19);

    full = {tok, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    chk("model_residual5", 64'(crc_of(full)), 64'h0C);
    clear_obs(); run_frame(full, 1'b1, 0, -1); idle(1);
    chk("s4_ok_pulses", 64'(n_ok), 64'd1);
    chk("s4_err_pulses", 64'(n_err), 64'd0);
    bad = full; bad[3] = ~bad[3];
    clear_obs(); run_frame(bad, 1'b1, 0, -1); idle(1);
    chk("s4b_err_pulses", 64'(n_err), 64'd1);
    chk("s4b_ok_pulses", 64'(n_ok), 64'd0);

    run_frame(tok, 1'b0, 0, 2); idle(1);
    clear_obs(); run_frame(z, 1'b0, 0, -1); idle(1);
    chk("s5_wire", obs_val, 64'b000100);
    chk("s5_send_cycles", 64'(n_send), 64'd6);

    rnd = {};
    repeat (9) rnd.push_back(1'($urandom));
    clear_obs(); run_frame(rnd, 1'b0, 0, -1); run_frame(tok, 1'b0, 0, -1); idle(1);
    chk("s6_second_tail", 64'(obs_val[4:0]), 64'h17);
    clear_obs(); run_frame(full, 1'b1, 0, -1); run_frame(full, 1'b1, 0, -1); idle(1);
    chk("s6_check_b2b_ok", 64'(n_ok), 64'd2);

    random_frames(40);

    sel16 = 1'b1; W = 16; poly = 16'h8005; res = 16'h800D; mask = 16'hFFFF;
    reset_seq();
    chk("model_crc16_bit1", 64'(crc_of(one)), 64'hFFFE);
    clear_obs(); run_frame(one, 1'b0, 0, -1); idle(1);
    chk("s2_count", 64'(obs_n), 64'd17);
    chk("s2_wire", 64'(obs_val[16:0]), 64'h10001);
    random_frames(20);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
